cordic_fp_addsub: RTL and testbench



---
 rtl/cordic_fp_pkg.sv | 22 ++
 rtl/cordic_lzc.sv | 20 ++
 rtl/cordic_fp_addsub.sv | 173 +++++++++++++++++
 tb/tb_cordic_fp_addsub.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cordic_fp_pkg.sv
// Shared definitions for the floating-point CORDIC datapath.
package cordic_fp_pkg;

    // Default packed format: {sign, exponent[DefE], mantissa[DefM]}
    localparam int unsigned DefM = 23;
    localparam int unsigned DefE = 8;

    // Field offsets inside a packed word of the default format
    localparam int unsigned MantLsb = 0;
    localparam int unsigned ExpLsb  = DefM;
    localparam int unsigned SignPos = DefM + DefE;

    // Add/sub sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm,
        StDone
    } state_e;

endpackage

// File: rtl/cordic_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module cordic_lzc #(
    parameter int unsigned W    = 24,
    parameter int unsigned CntW = $clog2(W + 1)
) (
    input  logic [W-1:0]    data_i,
    output logic [CntW-1:0] count_o
);

    // Scan upward so the highest set bit writes the count last
    always_comb begin
        count_o = CntW'(W);
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) begin
                count_o = CntW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/cordic_fp_addsub.sv
// Four-cycle floating-point add/subtract: align, add, normalise, hold result.
module cordic_fp_addsub
    import cordic_fp_pkg::*;
#(
    parameter int unsigned M = DefM,
    parameter int unsigned E = DefE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M+E:0] a,
    input  logic [M+E:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M+E:0] c
);

    localparam int unsigned SignAt     = M + E;
    localparam int unsigned LzW        = $clog2(M + 2);
    localparam logic [E:0]  ExpMax     = {1'b0, {E{1'b1}}};
    localparam logic [E:0]  ShiftLimit = (E + 1)'(M + 1);

    state_e       state_q, state_d;
    logic [M+E:0] a_q, a_d;
    logic [M+E:0] b_q, b_d;          // b with the subtract folded into its sign
    logic         sign_q, sign_d;
    logic         eff_sub_q, eff_sub_d;
    logic [E:0]   exp_l_q, exp_l_d;
    logic [M:0]   sig_l_q, sig_l_d;
    logic [M:0]   sig_s_q, sig_s_d;
    logic [M+1:0] sum_q, sum_d;
    logic [M+E:0] c_q, c_d;

    // Alignment signals
    logic [E-1:0] a_exp, b_exp, l_exp, s_exp;
    logic [M:0]   a_sig, b_sig, l_sig, s_sig, s_sig_sh;
    logic         a_is_l, l_sign;
    logic [E:0]   shamt;

    // Normalisation signals
    logic [LzW-1:0] lz;
    logic [E:0]     exp_inc;
    logic [E-1:0]   exp_dec;
    logic [M-1:0]   norm_man;

    cordic_lzc #(
        .W    (M + 1),
        .CntW (LzW)
    ) u_lzc (
        .data_i  (sum_q[M:0]),
        .count_o (lz)
    );

    // Order operands by magnitude and align the smaller significand
    always_comb begin
        a_exp  = a_q[M +: E];
        b_exp  = b_q[M +: E];
        a_sig  = (a_exp != '0) ? {1'b1, a_q[M-1:0]} : '0;
        b_sig  = (b_exp != '0) ? {1'b1, b_q[M-1:0]} : '0;
        // Exponent sits above mantissa, so the unsigned word compare orders magnitudes
        a_is_l = (a_q[SignAt-1:0] >= b_q[SignAt-1:0]);
        l_exp  = a_is_l ? a_exp : b_exp;
        s_exp  = a_is_l ? b_exp : a_exp;
        l_sig  = a_is_l ? a_sig : b_sig;
        s_sig  = a_is_l ? b_sig : a_sig;
        l_sign = a_is_l ? a_q[SignAt] : b_q[SignAt];
        shamt  = {1'b0, l_exp} - {1'b0, s_exp};
        s_sig_sh = (shamt > ShiftLimit) ? '0 : (s_sig >> shamt);
    end

    // Exponent adjust and left shift for the normalise step
    always_comb begin
        exp_inc  = exp_l_q + (E + 1)'(1);
        exp_dec  = E'(exp_l_q - (E + 1)'(lz));
        norm_man = M'(sum_q[M:0] << lz);
    end

    // Sequencer next state, datapath next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        exp_l_d   = exp_l_q;
        sig_l_d   = sig_l_q;
        sig_s_d   = sig_s_q;
        sum_d     = sum_q;
        c_d       = c_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = {b[SignAt] ^ sub, b[SignAt-1:0]};
                    state_d = StAlign;
                end
            end
            StAlign: begin
                sign_d    = l_sign;
                eff_sub_d = a_q[SignAt] ^ b_q[SignAt];
                exp_l_d   = {1'b0, l_exp};
                sig_l_d   = l_sig;
                sig_s_d   = s_sig_sh;
                state_d   = StAdd;
            end
            StAdd: begin
                // L is the larger magnitude, so the difference never goes negative
                sum_d   = eff_sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                                    : ({1'b0, sig_l_q} + {1'b0, sig_s_q});
                state_d = StNorm;
            end
            StNorm: begin
                if (sum_q == '0) begin
                    c_d = '0;
                end else if (sum_q[M+1]) begin
                    if (exp_inc > ExpMax) begin
                        c_d = {sign_q, {E{1'b1}}, {M{1'b1}}};
                    end else begin
                        c_d = {sign_q, exp_inc[E-1:0], sum_q[M:1]};
                    end
                end else if (exp_l_q <= (E + 1)'(lz)) begin
                    c_d = '0;
                end else begin
                    c_d = {sign_q, exp_dec, norm_man};
                end
                state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign c = c_q;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_l_q   <= '0;
            sig_l_q   <= '0;
            sig_s_q   <= '0;
            sum_q     <= '0;
            c_q       <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
            exp_l_q   <= exp_l_d;
            sig_l_q   <= sig_l_d;
            sig_s_q   <= sig_s_d;
            sum_q     <= sum_d;
            c_q       <= c_d;
        end
    end

endmodule

// File: tb/tb_cordic_fp_addsub.sv
// Directed bench for cordic_fp_addsub with a scoreboard of expected results.
module tb_cordic_fp_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    cordic_fp_addsub #(
        .M (23),
        .E (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected summary before it");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a negedge in IDLE; returns just after the accept edge
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                            input logic [31:0] expc, input bit push);
        check("in_ready before accept", in_ready, 1);
        a        = ta;
        b        = tb_v;
        sub      = ts;
        in_valid = 1'b1;
        if (push) exp_q.push_back(expc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Three busy cycles, then out_valid in the fourth; returns at that negedge
    task automatic wait_result(input string tag);
        logic [31:0] expc;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check({tag, " busy"}, {30'd0, out_valid, in_ready}, 32'd0);
        end
        @(negedge clk);
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " in_ready low"}, in_ready, 0);
        check({tag, " scoreboard nonempty"}, exp_q.size() != 0, 1);
        expc = exp_q.pop_front();
        check({tag, " c"}, c, expc);
    endtask

    task automatic op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                      input logic ts, input logic [31:0] expc);
        @(negedge clk);
        start_op(ta, tb_v, ts, expc, 1'b1);
        wait_result(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset c", c, 32'h0);

        op("add 1+2", 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);
        op("sub 1-0.5", 32'h3F80_0000, 32'h3F00_0000, 1'b1, 32'h3F00_0000);
        op("cancel", 32'h4040_0000, 32'h4040_0000, 1'b1, 32'h0000_0000);
        op("zero minus 2", 32'h0000_0000, 32'h4000_0000, 1'b1, 32'hC000_0000);
        op("far below", 32'h4B80_0000, 32'h3380_0000, 1'b0, 32'h4B80_0000);
        op("saturate", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF);
        op("underflow flush", 32'h00C0_0000, 32'h0080_0000, 1'b1, 32'h0000_0000);
        op("neg add", 32'hBF80_0000, 32'hBF80_0000, 1'b0, 32'hC000_0000);

        // Backpressure: hold DONE for 10 cycles while poking in_valid
        @(negedge clk);
        out_ready = 1'b0;
        start_op(32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 1'b1);
        wait_result("bp op");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = 32'h4040_0000 + 32'(i);
            b        = 32'h3F80_0000;
            sub      = i[0];
            @(negedge clk);
            check("bp out_valid held", out_valid, 1);
            check("bp c held", c, 32'h3F80_0000);
            check("bp in_ready low", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", out_valid, 0);
        start_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b1);
        wait_result("after bp");

        // Reset while in ADD discards the operation
        @(negedge clk);
        start_op(32'hC000_0000, 32'h3F80_0000, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst in_ready", in_ready, 1);
        check("midrst out_valid", out_valid, 0);
        check("midrst c", c, 32'h0);
        start_op(32'hC040_0000, 32'h3F80_0000, 1'b0, 32'hC000_0000, 1'b1);
        wait_result("after midrst");

        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
